// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster-order pixel stream in, 3x3 neighbourhood out.
// Two line buffers hold the previous two image lines; a 3x3 shift window
// doubles as the output register. Optional macro SOBEL_WIN_POS_EN adds
// win_col/win_row centre-pixel coordinates alongside the window.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds data and valid stable until the transfer;
// ready may change freely. Both the pixel input and window output obey this.
module sobel_window_gen #(
  parameter int PIX_W      = 9,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] in0,
  output logic [PIX_W-1:0] in1,
  output logic [PIX_W-1:0] in2,
  output logic [PIX_W-1:0] in3,
  output logic [PIX_W-1:0] in4,
  output logic [PIX_W-1:0] in5,
  output logic [PIX_W-1:0] in6,
  output logic [PIX_W-1:0] in7,
  output logic [PIX_W-1:0] in8,
  output logic             win_valid,
  input  logic             win_ready
`ifdef SOBEL_WIN_POS_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [PIX_W-1:0] r_lb0 [IMG_WIDTH];  // previous line
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];  // line before that
  logic [PIX_W-1:0] r_win [9];          // row-major, index 0 = top-left
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_win_valid;

  logic             w_accept;
  logic             w_emit;
  logic             w_col_last;
  logic             w_row_last;
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;

  // Accept/emit decode; a window is complete only once two full lines and
  // three pixels of the current line exist, so edges never emit.
  always_comb begin
    pix_ready  = !r_win_valid || win_ready;
    w_accept   = pix_valid && pix_ready;
    w_emit     = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
    w_col_last = (r_col == COL_LAST);
    w_row_last = (r_row == ROW_LAST);
    w_lb0_rd   = r_lb0[r_col];
    w_lb1_rd   = r_lb1[r_col];
  end

  // Raster position counters and output-valid tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_emit) begin
        r_win_valid <= 1'b1;
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  // 3x3 shift window: shift left on accept, new right column from the
  // line buffers and the incoming pixel. Only shifts when pix_ready, so a
  // stalled window is never disturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb1_rd;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb0_rd;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pix_in;
    end
  end

  // Line buffer update: each column ages one line per accepted pixel.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= pix_in;
    end
  end

`ifdef SOBEL_WIN_POS_EN
  logic [CW-1:0] r_win_col;
  logic [RW-1:0] r_win_row;

  // Centre coordinates of the emitted window, captured with the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_col <= '0;
      r_win_row <= '0;
    end else if (w_emit) begin
      r_win_col <= r_col - CW'(1);
      r_win_row <= r_row - RW'(1);
    end
  end

  assign win_col = r_win_col;
  assign win_row = r_win_row;
`endif

  assign in0       = r_win[0];
  assign in1       = r_win[1];
  assign in2       = r_win[2];
  assign in3       = r_win[3];
  assign in4       = r_win[4];
  assign in5       = r_win[5];
  assign in6       = r_win[6];
  assign in7       = r_win[7];
  assign in8       = r_win[8];
  assign win_valid = r_win_valid;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image. The reference model stores
// accepted pixels in a 2-D image array and cuts 3x3 windows from it.
// Build with SOBEL_WIN_POS_EN defined to also check win_col/win_row.
module tb_sobel_window_gen;

  localparam int PIX_W = 9;
  localparam int IW    = 4;
  localparam int IH    = 4;
  localparam int W     = 9 * PIX_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] in0, in1, in2, in3, in4, in5, in6, in7, in8;
  logic             win_valid;
  logic             win_ready;
`ifdef SOBEL_WIN_POS_EN
  logic [1:0]       win_col;
  logic [1:0]       win_row;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit rr_mode  = 1'b0;

  // scoreboard state
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     got_q[$];
  logic [3:0]       exp_pos_q[$];
  logic [3:0]       got_pos_q[$];
  logic [PIX_W-1:0] img [IH][IW];
  int               m_col = 0;
  int               m_row = 0;
  bit               prev_rst = 1'b1;
  bit               prev_stall = 1'b0;
  bit               emitted = 1'b0;
  logic [W-1:0]     prev_win;

  int lit1 [4][9] = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10},
                      '{1, 2, 3, 5, 6, 7, 9, 10, 11},
                      '{4, 5, 6, 8, 9, 10, 12, 13, 14},
                      '{5, 6, 7, 9, 10, 11, 13, 14, 15}};

  sobel_window_gen #(.PIX_W(PIX_W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk(clk), .rst(rst),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in5(in5), .in6(in6), .in7(in7), .in8(in8),
    .win_valid(win_valid), .win_ready(win_ready)
`ifdef SOBEL_WIN_POS_EN
    , .win_col(win_col), .win_row(win_row)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] dut_win();
    return {in0, in1, in2, in3, in4, in5, in6, in7, in8};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // random downstream ready when enabled
  initial forever begin
    @(posedge clk); #1;
    if (rr_mode) win_ready = 1'($urandom_range(0, 1));
  end

  // monitor + reference model, sampled on the falling edge
  always @(negedge clk) begin
    logic [W-1:0] w;
    logic [W-1:0] e;
    bit exp_valid;
    w = dut_win();
    exp_valid = !prev_rst && (emitted || prev_stall);
    chk(win_valid === exp_valid, "win_valid", 128'(win_valid), 128'(exp_valid));
    chk(pix_ready === (!win_valid || win_ready), "pix_ready_rule",
        128'(pix_ready), 128'(!win_valid || win_ready));
    if (prev_rst) chk(w === '0, "reset_window", 128'(w), 128'(0));
    if (prev_stall && !prev_rst) chk(w === prev_win, "hold_stable", 128'(w), 128'(prev_win));
    if (!rst && win_valid && win_ready) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_window", 128'(w), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk(w === e, "window_data", 128'(w), 128'(e));
`ifdef SOBEL_WIN_POS_EN
        begin
          logic [3:0] ep;
          ep = exp_pos_q.pop_front();
          chk({win_row, win_col} === ep, "window_pos", 128'({win_row, win_col}), 128'(ep));
          got_pos_q.push_back({win_row, win_col});
        end
`endif
      end
      got_q.push_back(w);
    end
    prev_rst   = rst;
    prev_stall = !rst && win_valid && !win_ready;
    prev_win   = w;
    emitted    = 1'b0;
    if (rst) begin
      m_col = 0;
      m_row = 0;
      exp_q.delete();
      exp_pos_q.delete();
    end else if (pix_valid && pix_ready) begin
      img[m_row][m_col] = pix_in;
      if (m_row >= 2 && m_col >= 2) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e[(8 - (r * 3 + c)) * PIX_W +: PIX_W] = img[m_row - 2 + r][m_col - 2 + c];
        exp_q.push_back(e);
        exp_pos_q.push_back({2'(m_row - 1), 2'(m_col - 1)});
        emitted = 1'b1;
      end
      m_col++;
      if (m_col == IW) begin
        m_col = 0;
        m_row = (m_row == IH - 1) ? 0 : m_row + 1;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [PIX_W-1:0] p, input bit gaps);
    bit acc;
    int n;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    pix_in = p;
    pix_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk(1'b0, "send_timeout", 128'(0), 128'(1));
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input int base, input bit gaps);
    for (int i = 0; i < IW * IH; i++) send(PIX_W'(base + i), gaps);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(exp_q.size() == 0, "drain", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_lit(input string nm, input int first, input int off);
    logic [W-1:0] e;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 9; j++) e[(8 - j) * PIX_W +: PIX_W] = PIX_W'(lit1[k][j] + off);
      if (got_q.size() > first + k)
        chk(got_q[first + k] === e, nm, 128'(got_q[first + k]), 128'(e));
      else
        chk(1'b0, nm, 128'(0), 128'(e));
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_in = '0;
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk(win_valid === 1'b0, "rst_win_valid", 128'(win_valid), 128'(0));
    chk(pix_ready === 1'b1, "rst_pix_ready", 128'(pix_ready), 128'(1));
    chk(dut_win() === '0, "rst_window", 128'(dut_win()), 128'(0));

    // single frame 0..15, full throughput
    got_q.delete();
    got_pos_q.delete();
    run_frame(0, 1'b0);
    drain();
    chk(got_q.size() == 4, "t1_count", 128'(got_q.size()), 128'(4));
    check_lit("t1_window", 0, 0);
`ifdef SOBEL_WIN_POS_EN
    chk(got_pos_q.size() == 4 && got_pos_q[0] == 4'h5 && got_pos_q[1] == 4'h6 &&
        got_pos_q[2] == 4'h9 && got_pos_q[3] == 4'hA, "t6_positions",
        128'(got_pos_q.size()), 128'(4));
`endif

    // back-to-back frames
    got_q.delete();
    run_frame(0, 1'b0);
    run_frame(100, 1'b0);
    drain();
    chk(got_q.size() == 8, "t2_count", 128'(got_q.size()), 128'(8));
    check_lit("t2_frame1", 0, 0);
    check_lit("t2_frame2", 4, 100);

    // downstream stall of 5 clocks on the first window
    got_q.delete();
    fork
      run_frame(0, 1'b0);
      begin
        int n;
        logic [W-1:0] e;
        for (int j = 0; j < 9; j++) e[(8 - j) * PIX_W +: PIX_W] = PIX_W'(lit1[0][j]);
        n = 0;
        while (!win_valid && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
        chk(win_valid === 1'b1, "t3_first_valid", 128'(win_valid), 128'(1));
        win_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          chk(pix_ready === 1'b0, "t3_stall_ready", 128'(pix_ready), 128'(0));
          chk(dut_win() === e && win_valid === 1'b1, "t3_stall_window",
              128'(dut_win()), 128'(e));
        end
        win_ready = 1'b1;
      end
    join
    drain();
    chk(got_q.size() == 4, "t3_count", 128'(got_q.size()), 128'(4));
    check_lit("t3_window", 0, 0);

    // random pix_valid gaps
    got_q.delete();
    run_frame(0, 1'b1);
    drain();
    chk(got_q.size() == 4, "t4_count", 128'(got_q.size()), 128'(4));
    check_lit("t4_window", 0, 0);

    // mid-frame reset after pixel 7
    for (int i = 0; i < 8; i++) send(PIX_W'(i), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk(win_valid === 1'b0, "t5_valid_after_rst", 128'(win_valid), 128'(0));
    got_q.delete();
    run_frame(0, 1'b0);
    drain();
    chk(got_q.size() == 4, "t5_count", 128'(got_q.size()), 128'(4));
    check_lit("t5_window", 0, 0);

    // random pixels incl. max value, random valid and ready
    got_q.delete();
    rr_mode = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < IW * IH; i++)
        send((i == 5) ? PIX_W'(511) : PIX_W'($urandom_range(0, 511)), 1'b1);
    rr_mode = 1'b0;
    @(posedge clk); #2;
    win_ready = 1'b1;
    drain();
    chk(got_q.size() == 12, "rand_count", 128'(got_q.size()), 128'(12));
    if (got_q.size() > 0)
      chk(got_q[0][4 * PIX_W +: PIX_W] === PIX_W'(511), "rand_max_pixel",
          128'(got_q[0][4 * PIX_W +: PIX_W]), 128'(511));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
